fpnew_result_buffer: RTL and testbench

//   Output stage directly downstream of fpnew_top: accepts result/status/tag beats over a valid/ready

---
 rtl/fpnew_result_buffer.sv | 105 ++++++++++
 tb/tb_fpnew_result_buffer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_result_buffer.sv
// In-order result FIFO behind fpnew_top with sticky fflags accumulation.
// Full buffer refuses pushes regardless of same-cycle pops.
module fpnew_result_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_result_i,
    input  logic [4:0]                   in_status_i,
    input  logic [TAG_WIDTH-1:0]         in_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_result_o,
    output logic [4:0]                   out_status_o,
    output logic [TAG_WIDTH-1:0]         out_tag_o,
    output logic [4:0]                   fflags_o,
    input  logic                         fflags_clr_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [WIDTH-1:0]     res_q [DEPTH];
    logic [4:0]           sts_q [DEPTH];
    logic [TAG_WIDTH-1:0] tag_q [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      fflags_q, fflags_d;
    logic            push, pop;

    assign in_ready_o  = (cnt_q != Full);
    assign out_valid_o = (cnt_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign out_result_o = out_valid_o ? res_q[rd_ptr_q] : '0;
    assign out_status_o = out_valid_o ? sts_q[rd_ptr_q] : '0;
    assign out_tag_o    = out_valid_o ? tag_q[rd_ptr_q] : '0;
    assign fflags_o     = fflags_q;
    assign count_o      = cnt_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        fflags_d = fflags_q;
        if (flush_i) begin
            // Flushed pops are discarded, so their status never reaches fflags.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            if (fflags_clr_i) begin
                fflags_d = '0;
            end
        end else begin
            if (fflags_clr_i) begin
                fflags_d = '0;
            end
            if (pop) begin
                fflags_d = fflags_d | out_status_o;
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            res_q[wr_ptr_q] <= in_result_i;
            sts_q[wr_ptr_q] <= in_status_i;
            tag_q[wr_ptr_q] <= in_tag_i;
        end
    end

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Bench for fpnew_result_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the buffer.
module tb_fpnew_result_buffer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_status;
    logic [0:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_status;
    logic [0:0]  out_tag;
    logic [4:0]  fflags;
    logic        clr;
    logic [2:0]  count;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  st;
        logic [0:0]  tag;
    } beat_t;

    beat_t      mq[$];
    logic [4:0] mflags;
    int         checks;
    int         failures;

    always #5 clk = ~clk;

    fpnew_result_buffer #(
        .WIDTH(32),
        .TAG_WIDTH(1),
        .DEPTH(D)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_result_i (in_result),
        .in_status_i (in_status),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_result_o(out_result),
        .out_status_o(out_status),
        .out_tag_o   (out_tag),
        .fflags_o    (fflags),
        .fflags_clr_i(clr),
        .count_o     (count)
    );

    task automatic idle();
        rst_n     = 1'b1;
        flush     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_result = '0;
        in_status = '0;
        in_tag    = '0;
    endtask

    // Advance one clock and update the reference model with the applied inputs.
    task automatic cycle();
        bit    do_push;
        bit    do_pop;
        beat_t b;
        do_push = in_valid && (mq.size() != D);
        do_pop  = out_ready && (mq.size() != 0);
        b = '{in_result, in_status, in_tag};
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            mflags = '0;
        end else if (flush) begin
            mq.delete();
            if (clr) mflags = '0;
        end else begin
            if (clr) mflags = '0;
            if (do_pop) begin
                mflags = mflags | mq[0].st;
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back(b);
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        clr      = 1'b1;
        in_result = 32'hdead_beef;
        cycle();
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (fflags !== 5'b0) begin
            failures++;
            $display("FAIL reset_fflags got=%b exp=00000", fflags);
        end
        checks++;
        if (out_result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", out_result);
        end
    endtask

    task automatic test_single();
        idle();
        in_valid  = 1'b1;
        in_result = 32'h4000_0000;
        in_status = 5'b00001;
        in_tag    = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_nobypass got=%b exp=0", out_valid);
        end
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h4000_0000) begin
            failures++;
            $display("FAIL single_head got=%b/%h exp=1/40000000",
                     out_valid, out_result);
        end
        checks++;
        if (out_tag !== 1'b1 || out_status !== 5'b00001) begin
            failures++;
            $display("FAIL single_tag got=%b/%b exp=1/00001",
                     out_tag, out_status);
        end
        out_ready = 1'b1;
        cycle();
        idle();
        checks++;
        if (count !== 3'd0 || fflags !== 5'b00001) begin
            failures++;
            $display("FAIL single_pop got=%0d/%b exp=0/00001", count, fflags);
        end
        checks++;
        if (out_result !== 32'h0) begin
            failures++;
            $display("FAIL single_empty_zero got=%h exp=0", out_result);
        end
    endtask

    task automatic test_fill();
        int  exp;
        bit  acc;
        idle();
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_result = 32'(i);
            cycle();
            if (i == 4) begin
                checks++;
                if (in_ready !== 1'b0 || count !== 3'd4) begin
                    failures++;
                    $display("FAIL fill_full got=%b/%0d exp=0/4", in_ready, count);
                end
            end
        end
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL fill_held got=%0d exp=4", count);
        end
        out_ready = 1'b1;
        exp = 1;
        for (int k = 0; k < 12 && exp <= 5; k++) begin
            if (out_valid) begin
                checks++;
                if (out_result !== 32'(exp)) begin
                    failures++;
                    $display("FAIL fill_order got=%h exp=%h", out_result, 32'(exp));
                end
                exp++;
            end
            acc = in_valid && (mq.size() != D);
            cycle();
            if (acc) in_valid = 1'b0;
        end
        if (exp <= 5) begin
            checks++;
            failures++;
            $display("FAIL fill_timeout got=%0d exp=6", exp);
        end
        idle();
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL fill_drained got=%0d exp=0", count);
        end
    endtask

    task automatic test_full_pop();
        idle();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_result = 32'h10 + 32'(i);
            cycle();
        end
        in_result = 32'haa;
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_ready got=%b exp=0", in_ready);
        end
        cycle();
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fullpop_poponly got=%0d/%b exp=3/1", count, in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL fullpop_both got=%0d exp=3", count);
        end
        for (int k = 0; k < 8 && mq.size() != 0; k++) begin
            checks++;
            if (out_result !== mq[0].res) begin
                failures++;
                $display("FAIL fullpop_drain got=%h exp=%h", out_result, mq[0].res);
            end
            cycle();
        end
        idle();
    endtask

    task automatic test_stream();
        idle();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_result = 32'd200 + 32'(k);
            in_tag    = 1'(k);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== 32'd200 + 32'(k - 1)
                    || count !== 3'd1) begin
                    failures++;
                    $display("FAIL stream_beat got=%b/%0d/%0d exp=1/%0d/1",
                             out_valid, out_result, count, 200 + k - 1);
                end
            end
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (out_result !== 32'd209) begin
            failures++;
            $display("FAIL stream_last got=%0d exp=209", out_result);
        end
        cycle();
        idle();
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL stream_empty got=%0d exp=0", count);
        end
    endtask

    task automatic test_flush();
        idle();
        clr = 1'b1;
        cycle();
        idle();
        in_valid  = 1'b1;
        in_status = 5'b10000;
        cycle();
        idle();
        out_ready = 1'b1;
        cycle();
        idle();
        in_valid  = 1'b1;
        in_status = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            in_result = 32'h300 + 32'(i);
            cycle();
        end
        checks++;
        if (count !== 3'd3 || fflags !== 5'b10000) begin
            failures++;
            $display("FAIL flush_pre got=%0d/%b exp=3/10000", count, fflags);
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        idle();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || fflags !== 5'b10000) begin
            failures++;
            $display("FAIL flush_post got=%0d/%b/%b exp=0/0/10000",
                     count, out_valid, fflags);
        end
        in_valid  = 1'b1;
        in_status = 5'b00100;
        cycle();
        idle();
        clr       = 1'b1;
        out_ready = 1'b1;
        cycle();
        idle();
        checks++;
        if (fflags !== 5'b00100 || count !== 3'd0) begin
            failures++;
            $display("FAIL flush_clrpop got=%b/%0d exp=00100/0", fflags, count);
        end
    endtask

    task automatic test_random();
        logic [31:0] er;
        logic [4:0]  es;
        logic [0:0]  et;
        idle();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            clr       = ($urandom_range(0, 15) == 0);
            in_result = $urandom;
            in_status = 5'($urandom);
            in_tag    = 1'($urandom);
            er = (mq.size() != 0) ? mq[0].res : '0;
            es = (mq.size() != 0) ? mq[0].st  : '0;
            et = (mq.size() != 0) ? mq[0].tag : '0;
            checks++;
            if (out_result !== er || out_status !== es || out_tag !== et) begin
                failures++;
                $display("FAIL rand_head got=%h/%b/%b exp=%h/%b/%b",
                         out_result, out_status, out_tag, er, es, et);
            end
            checks++;
            if (count !== 3'(mq.size()) || in_ready !== (mq.size() != D)
                || out_valid !== (mq.size() != 0)) begin
                failures++;
                $display("FAIL rand_count got=%0d/%b/%b exp=%0d",
                         count, in_ready, out_valid, mq.size());
            end
            checks++;
            if (fflags !== mflags) begin
                failures++;
                $display("FAIL rand_fflags got=%b exp=%b", fflags, mflags);
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mflags   = '0;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
